// File: rtl/imm_ext_pipe_pkg.sv
// imm_ext_pipe_pkg: LA32R immediate-extension mode codes shared by decode and issue.
package imm_ext_pipe_pkg;
    typedef enum logic [2:0] {
        EXT_20  = 3'd0,
        EXT_12  = 3'd1,
        EXT_12Z = 3'd2,
        EXT_5   = 3'd3,
        EXT_16  = 3'd4,
        EXT_26  = 3'd5,
        EXT_14  = 3'd6,
        EXT_RAW = 3'd7
    } ext_op_t;
endpackage

// File: rtl/imm_ext_core.sv
// imm_ext_core: combinational LA32R immediate extraction and sign/zero extension to XLEN.
module imm_ext_core
    import imm_ext_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [25:0]     din,
    input  logic [2:0]      op,
    output logic [XLEN-1:0] imm
);
    // Branch and ll/sc offsets come out already scaled by 4.
    always_comb begin
        imm = '0;
        case (ext_op_t'(op))
            EXT_20:  imm = XLEN'($signed({din[24:5], 12'h000}));
            EXT_12:  imm = XLEN'($signed(din[21:10]));
            EXT_12Z: imm = XLEN'(din[21:10]);
            EXT_5:   imm = XLEN'(din[14:10]);
            EXT_16:  imm = XLEN'($signed({din[25:10], 2'b00}));
            EXT_26:  imm = XLEN'($signed({din[9:0], din[25:10], 2'b00}));
            EXT_14:  imm = XLEN'($signed({din[23:10], 2'b00}));
            EXT_RAW: imm = XLEN'(din);
            default: imm = '0;
        endcase
    end
endmodule

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: registered, skid-buffered immediate-extension stage with sideband tag.
// Optional IMM_EXT_TARGET_EN adds in_pc/out_target (pc + immediate, carried with the entry).
module imm_ext_pipe
    import imm_ext_pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [25:0]      in_din,
    input  logic [2:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
`ifdef IMM_EXT_TARGET_EN
    input  logic [XLEN-1:0]  in_pc,
    output logic [XLEN-1:0]  out_target,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag
);
`ifdef IMM_EXT_TARGET_EN
    localparam int DW = 2 * XLEN + TAG_W;
`else
    localparam int DW = XLEN + TAG_W;
`endif
    logic [XLEN-1:0] imm;
    logic [DW-1:0]   in_data, main_q, skid_q;
    logic            skid_valid, acc, cons;

    imm_ext_core #(.XLEN(XLEN)) u_core (.din(in_din), .op(in_op), .imm(imm));

`ifdef IMM_EXT_TARGET_EN
    assign in_data    = {in_pc + imm, imm, in_tag};
    assign out_target = main_q[DW-1 -: XLEN];
`else
    assign in_data = {imm, in_tag};
`endif
    assign out_imm  = main_q[TAG_W +: XLEN];
    assign out_tag  = main_q[TAG_W-1:0];
    assign in_ready = !skid_valid;
    assign acc      = in_valid && in_ready;
    assign cons     = out_valid && out_ready;

    // in_ready is low whenever skid is full, so skid drain and accept never coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            if (cons) begin
                main_q     <= skid_q;
                skid_valid <= 1'b0;
            end
        end else if (acc && out_valid && !cons) begin
            skid_q     <= in_data;
            skid_valid <= 1'b1;
        end else if (acc) begin
            main_q    <= in_data;
            out_valid <= 1'b1;
        end else if (cons) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb_imm_ext_pipe: directed and random stimulus against a queue-based reference of imm_ext_pipe.
module tb_imm_ext_pipe;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [25:0] in_din;
    logic [2:0]  in_op;
    logic [31:0] in_tag, out_imm, out_tag, pc;
`ifdef IMM_EXT_TARGET_EN
    logic [31:0] in_pc, out_target;
`endif
    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic [31:0] imm;
        logic [31:0] tag;
        logic [31:0] tgt;
    } ent_t;
    ent_t q[$];

    imm_ext_pipe #(.XLEN(32), .TAG_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_din(in_din), .in_op(in_op), .in_tag(in_tag),
`ifdef IMM_EXT_TARGET_EN
        .in_pc(in_pc), .out_target(out_target),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    // Field value as a signed integer, scaled, then wrapped to 32 bits.
    function automatic logic [31:0] ref_imm(input logic [2:0] op, input logic [25:0] d);
        longint v;
        case (op)
            3'd0: v = longint'(d[24:5]) * 4096;
            3'd1: begin v = longint'(d[21:10]); if (v >= 2048) v -= 4096; end
            3'd2: v = longint'(d[21:10]);
            3'd3: v = longint'(d[14:10]);
            3'd4: begin v = longint'(d[25:10]); if (v >= 32768) v -= 65536; v *= 4; end
            3'd5: begin v = longint'(d[9:0]) * 65536 + longint'(d[25:10]); if (v >= 33554432) v -= 67108864; v *= 4; end
            3'd6: begin v = longint'(d[23:10]); if (v >= 8192) v -= 16384; v *= 4; end
            default: v = longint'(d);
        endcase
        return v[31:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        compared++;
        assert (got === want) else begin
            mismatched++;
            $error("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic cyc(input logic v, input logic [2:0] op, input logic [25:0] din,
                       input logic [31:0] tag, input logic ordy, input logic fl);
        logic acc, cons;
        ent_t e;
        in_valid = v; in_op = op; in_din = din; in_tag = tag; out_ready = ordy; flush = fl;
`ifdef IMM_EXT_TARGET_EN
        in_pc = pc;
`endif
        @(negedge clk);
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        if (q.size() > 0) begin
            chk("out_imm", out_imm, q[0].imm);
            chk("out_tag", out_tag, q[0].tag);
`ifdef IMM_EXT_TARGET_EN
            chk("out_target", out_target, q[0].tgt);
`endif
        end
        acc  = v && (q.size() < 2);
        cons = (q.size() > 0) && ordy;
        e.imm = ref_imm(op, din);
        e.tag = tag;
        e.tgt = pc + e.imm;
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (cons) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        #1;
    endtask

    task automatic rnd(input int n, input int v_pct, input int r_pct, input int f_pct);
        for (int i = 0; i < n; i++) begin
            pc = $urandom;
            cyc($urandom_range(99) < v_pct, 3'($urandom), 26'($urandom), $urandom,
                $urandom_range(99) < r_pct, $urandom_range(99) < f_pct);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_din = '0; in_op = '0; in_tag = '0; pc = '0;
`ifdef IMM_EXT_TARGET_EN
        in_pc = '0;
`endif
        @(posedge clk); #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_imm", out_imm, 32'd0);
        chk("rst_out_tag", out_tag, 32'd0);
        rst = 1'b0;
        // single beats and formats
        cyc(1, 3'd1, 26'h03FFC00, 32'hA1, 1, 0); chk("ext12", out_imm, 32'hFFFFFFFF);
        cyc(1, 3'd2, 26'h03FFC00, 32'hA2, 1, 0); chk("ext12z", out_imm, 32'h00000FFF);
        cyc(1, 3'd0, 26'h02468A0, 32'hA3, 1, 0); chk("ext20", out_imm, 32'h12345000);
        cyc(1, 3'd4, 26'h2000000, 32'hA4, 1, 0); chk("ext16", out_imm, 32'hFFFE0000);
        cyc(1, 3'd5, 26'h3FFFFFF, 32'hA5, 1, 0); chk("ext26", out_imm, 32'hFFFFFFFC);
        cyc(1, 3'd3, 26'h0007C00, 32'hA6, 1, 0); chk("ext5", out_imm, 32'h0000001F);
        cyc(0, 3'd0, 26'h0, 32'h0, 1, 0);
        // backpressure
        cyc(1, 3'($urandom), 26'($urandom), 32'd1, 0, 0);
        cyc(1, 3'($urandom), 26'($urandom), 32'd2, 0, 0);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_hold_tag", out_tag, 32'd1);
        cyc(1, 3'd7, 26'h1234567, 32'd3, 0, 0);
        cyc(1, 3'd7, 26'h1234567, 32'd3, 1, 0); chk("bp_tag2", out_tag, 32'd2);
        cyc(1, 3'd7, 26'h1234567, 32'd3, 1, 0); chk("bp_tag3", out_tag, 32'd3);
        cyc(0, 3'd0, 26'h0, 32'h0, 1, 0);
        // simultaneous accept and consume
        rnd(20, 100, 100, 0);
        // flush with two buffered and a same-cycle beat
        cyc(1, 3'($urandom), 26'($urandom), 32'd11, 0, 0);
        cyc(1, 3'($urandom), 26'($urandom), 32'd12, 0, 0);
        cyc(1, 3'($urandom), 26'($urandom), 32'd13, 1, 1);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        cyc(0, 3'd0, 26'h0, 32'h0, 1, 0);
        // random traffic
        rnd(300, 60, 60, 5);
        // async reset between edges
        cyc(1, 3'($urandom), 26'($urandom), 32'd21, 0, 0);
        cyc(1, 3'($urandom), 26'($urandom), 32'd22, 0, 0);
        #3; rst = 1'b1; in_valid = 1'b0; #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_out_imm", out_imm, 32'd0);
        q.delete();
        #2; rst = 1'b0;
        @(posedge clk); #1;
        rnd(100, 60, 60, 3);
`ifdef IMM_EXT_TARGET_EN
        pc = 32'h1C000100;
        cyc(1, 3'd4, 26'h3FFFC00, 32'hB1, 1, 0);
        chk("target_b", out_target, 32'h1C0000FC);
        cyc(0, 3'd0, 26'h0, 32'h0, 1, 0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
- Registered, handshaked immediate-extension stage between decode and issue in the LA32R pipeline.
- Covers all LA32R immediate formats, including the branch offsets (offs16, offs26) and the ll/sc si14 offset, each pre-shifted.
- One-cycle latency, full throughput, skid-buffered so in_ready is a registered signal.
- Opaque sideband tag carried alongside (e.g. PC or ROB id).

Parameters:
- XLEN, 32, width of the extended immediate; legal range 32..64; sign/zero fill to XLEN.
- TAG_W, 32, width of the sideband tag passed through unchanged.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous kill of all buffered entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept; registered, equals !skid_valid
- in_din  in  26  instruction bits [25:0]
- in_op  in  3  extension mode, EXT_* code
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  output entry valid
- out_ready  in  1  downstream accepts
- out_imm  out  XLEN  extended immediate
- out_tag  out  TAG_W  tag of the output entry

Behaviour:
- Modes (in_op), with s=sign-extend and z=zero-extend to XLEN:
  - 0 EXT_20: {din[24:5],12'h0}, s from bit 31
  - 1 EXT_12: s(din[21:10])
  - 2 EXT_12Z: z(din[21:10])
  - 3 EXT_5: z(din[14:10])
  - 4 EXT_16: s({din[25:10],2'b00})
  - 5 EXT_26: s({din[9:0],din[25:10],2'b00})
  - 6 EXT_14: s({din[23:10],2'b00})
  - 7 EXT_RAW: z(din)
- Extension is computed combinationally at input; only results are stored, never raw din.
- Storage: main register (out_*) plus one skid register.
- Accept when in_valid & in_ready; the entry appears on out_* the next cycle (latency 1).
- Main register loads from the input when main is empty or the main entry is consumed (out_valid & out_ready) in the same cycle.
- If main is held (out_valid & !out_ready) and an input is accepted, the entry goes to skid; in_ready drops next cycle.
- When main is consumed and skid is full, skid moves to main in that cycle. Skid empties and in_ready rises next cycle. Any simultaneous input is not accepted because in_ready is low.
- Order is strictly FIFO; max occupancy is 2; no entry is lost or duplicated.
- flush: both valids clear at the next edge. flush has priority over a same-cycle accept, and the accepted entry is dropped. The out_ready handshake in the flush cycle still counts as consumed.
- Reset (async, rst=1): out_valid=0, skid_valid=0, in_ready=1, out_imm=0, out_tag=0. Reset asserted mid-transfer discards contents; the first accept after release behaves as from empty.
- out_imm/out_tag hold their value when out_valid=0; consumers must qualify with out_valid.
- No combinational path from out_ready to in_ready.

Optional Feature:
- Macro: IMM_EXT_TARGET_EN.
- Defined:
  - adds port in_pc (in, XLEN) and out_target (out, XLEN).
  - out_target = in_pc + extended immediate, computed at input and registered with the entry through main/skid.
  - serves b/bl/beq* targets and pcaddu12i.
  - out_target resets to 0.
  - wraps modulo 2^XLEN.
- Undefined: ports absent, no adder, behaviour otherwise identical.

Decomposition:
- EXT_* opcodes (3-bit, values above) stay in the shared defines.vh beside the existing decode constants; add EXT_16, EXT_26, EXT_14, EXT_RAW there.
- Sub-module imm_ext_core: purely combinational din/op -> XLEN immediate, parametrised by XLEN and reusable by other stages.
- imm_ext_pipe owns only the skid/handshake logic.

Test Plan:
- Reset then single beat: op=1, din[21:10]=12'hFFF, out_ready=1 -> next cycle out_valid=1, out_imm=32'hFFFFFFFF; op=2, same din -> 32'h00000FFF.
- Formats: op=0, din[24:5]=20'h12345 -> 32'h12345000. op=4, din[25:10]=16'h8000 -> 32'hFFFE0000. op=5, din=26'h3FFFFFF -> 32'hFFFFFFFC. op=3, din[14:10]=5'h1F -> 32'h1F.
- Backpressure: stream tags 1,2,3 with out_ready=0 -> tag1 held on out, tag2 in skid, in_ready=0 from the cycle after tag2's accept. Raise out_ready -> out shows 1,2,3 in order, no duplicates.
- Simultaneous: main full, out_ready=1, in_valid=1 every cycle -> one result per cycle, in_ready stays 1.
- Flush: two entries buffered plus flush with an in_valid beat -> next cycle out_valid=0, in_ready=1, flushed beat never appears.
- Async reset mid-stream (rst pulsed between edges) -> out_valid=0 immediately. With IMM_EXT_TARGET_EN: pc=32'h1C000100, op=4, offs16=16'hFFFF -> out_target=32'h1C0000FC.
